// File: rtl/dvi_a_pkg.sv
// Shared definitions for the DVI-A capture path:
// FSM encoding, 640x480 timing, pixel expansion.
package dvi_a_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_CAPTURE = 2'd2
  } cap_state_t;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;
  localparam int XY_W   = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_beat_t;

  // Bit replication keeps full-scale codes at 8'hFF.
  function automatic logic [31:0] rgb332_to_rgba(
    input logic [2:0] r,
    input logic [2:0] g,
    input logic [1:0] b
  );
    return {8'hFF, r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

endpackage

// File: rtl/dvi_a_sync_fifo.sv
// First-word fall-through synchronous FIFO.
// A pop on a full FIFO frees the slot for a same-cycle push.
module dvi_a_sync_fifo #(
  parameter int WIDTH = 52,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] pop_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dvi_a_capture.sv
// Captures a CAP_W x CAP_H window of RGB332 video into
// framebuffer writes through a small FWFT buffer.
module dvi_a_capture
  import dvi_a_pkg::*;
#(
  parameter int CAP_W      = 128,
  parameter int CAP_H      = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        video_hsync,
  input  logic        video_vsync,
  input  logic        video_de,
  input  logic [2:0]  video_red,
  input  logic [2:0]  video_green,
  input  logic [1:0]  video_blue,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [19:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow
);

  localparam logic [10:0] CW11 = 11'(CAP_W);
  localparam logic [10:0] CH11 = 11'(CAP_H);
  localparam logic [19:0] CW20 = 20'(CAP_W);
  localparam logic [9:0]  XY_MAX = 10'h3FF;

  cap_state_t state, state_n;

  logic       hs_r, vs_r, de_r;
  logic       vs_p, de_p;
  logic [2:0] r_r, g_r;
  logic [1:0] b_r;
  logic       vs_rise, de_fall;
  logic       enter_cap, exit_cap;
  logic       unused_hs;

  logic [XY_W-1:0] x, y;
  logic            push_now;

  logic     st_v;
  wr_beat_t st_beat;

  logic     fifo_full, fifo_empty, pop;
  wr_beat_t head;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_r <= 1'b0;
      vs_r <= 1'b0;
      de_r <= 1'b0;
      vs_p <= 1'b0;
      de_p <= 1'b0;
      r_r  <= '0;
      g_r  <= '0;
      b_r  <= '0;
    end else begin
      hs_r <= video_hsync;
      vs_r <= video_vsync;
      de_r <= video_de;
      vs_p <= vs_r;
      de_p <= de_r;
      r_r  <= video_red;
      g_r  <= video_green;
      b_r  <= video_blue;
    end
  end

  assign unused_hs = hs_r;
  assign vs_rise   = vs_r && !vs_p;
  assign de_fall   = !de_r && de_p;

  always_ff @(posedge vga_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    enter_cap = 1'b0;
    exit_cap  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable) state_n = S_WAIT_VS;
      end
      S_WAIT_VS: begin
        if (vs_rise) begin
          state_n   = S_CAPTURE;
          enter_cap = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (vs_rise) begin
          state_n  = enable ? S_WAIT_VS : S_IDLE;
          exit_cap = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Line advance is keyed to the end of active video, not hsync.
  always_ff @(posedge vga_clk) begin
    if (reset || enter_cap) begin
      x <= '0;
      y <= '0;
    end else if (state == S_CAPTURE) begin
      if (de_r) begin
        if (x != XY_MAX) x <= x + 10'd1;
      end else if (de_fall) begin
        x <= '0;
        if (y != XY_MAX) y <= y + 10'd1;
      end
    end
  end

  assign push_now = (state == S_CAPTURE) && de_r &&
                    ({1'b0, x} < CW11) && ({1'b0, y} < CH11);

  // One register stage ahead of the buffer holds the address product.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      st_v    <= 1'b0;
      st_beat <= '0;
    end else begin
      st_v <= push_now;
      if (push_now) begin
        st_beat.addr <= 20'(y) * CW20 + 20'(x);
        st_beat.data <= rgb332_to_rgba(r_r, g_r, b_r);
      end
    end
  end

  assign pop = !fifo_empty && wr_ready;

  dvi_a_sync_fifo #(
    .WIDTH($bits(wr_beat_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (vga_clk),
    .reset     (reset),
    .push      (st_v),
    .push_data (st_beat),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .pop_data  (head)
  );

  assign wr_valid = !fifo_empty;
  assign wr_addr  = head.addr;
  assign wr_data  = head.data;
  assign busy     = (state == S_CAPTURE);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= exit_cap;
      if (enter_cap)
        overflow <= 1'b0;
      else if (st_v && fifo_full && !pop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dvi_a_capture.sv
// Directed bench for dvi_a_capture on a shrunken raster:
// 160x13 total, 136x10 active, capture window 128x8.
module tb_dvi_a_capture;

  localparam int CW  = 128;
  localparam int CH  = 8;
  localparam int HT  = 160;
  localparam int HA  = 136;
  localparam int VT  = 13;
  localparam int VA0 = 3;
  localparam int NPX = CW * CH;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        video_hsync;
  logic        video_vsync;
  logic        video_de;
  logic [2:0]  video_red;
  logic [2:0]  video_green;
  logic [1:0]  video_blue;
  logic        wr_valid;
  logic        wr_ready;
  logic [19:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        frame_done;
  logic        overflow;

  always #5 vga_clk = ~vga_clk;

  dvi_a_capture #(
    .CAP_W(CW),
    .CAP_H(CH),
    .FIFO_DEPTH(4)
  ) dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .enable      (enable),
    .video_hsync (video_hsync),
    .video_vsync (video_vsync),
    .video_de    (video_de),
    .video_red   (video_red),
    .video_green (video_green),
    .video_blue  (video_blue),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  int vec = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [51:0] q[$];
  logic l1_busy;
  logic l1_ovf;

  always @(negedge vga_clk) begin
    if (!reset && wr_valid && wr_ready) q.push_back({wr_addr, wr_data});
    if (frame_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge vga_clk);
    #1;
  endtask

  function automatic logic [31:0] exp_px(input int a);
    logic [9:0] xv, yv;
    logic [2:0] r, g;
    logic [1:0] b;
    xv = 10'(a % CW);
    yv = 10'(a / CW);
    r  = xv[2:0];
    g  = yv[2:0];
    b  = xv[1:0] ^ yv[1:0];
    return {8'hFF, r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

  task automatic frame(input int st_l, input int st_px, input int st_n,
                       input int rs_l, input int rs_px, input int dis_l);
    logic [9:0] xv, yv;
    for (int l = 0; l < VT; l++) begin
      if (l == dis_l) enable = 1'b0;
      for (int px = 0; px < HT; px++) begin
        xv = 10'(px);
        yv = 10'(l - VA0);
        video_vsync = (l < 2);
        video_hsync = (px >= 140 && px < 148);
        video_de    = (l >= VA0 && px < HA);
        video_red   = video_de ? xv[2:0] : 3'd0;
        video_green = video_de ? yv[2:0] : 3'd0;
        video_blue  = video_de ? (xv[1:0] ^ yv[1:0]) : 2'd0;
        wr_ready    = !(l == st_l && px >= st_px && px < st_px + st_n);
        if (l == rs_l && px == rs_px) begin
          chk("pre_rst_valid", 32'(wr_valid), 1);
          reset = 1'b1;
          tick();
          chk("rst_valid", 32'(wr_valid), 0);
          chk("rst_addr", 32'(wr_addr), 0);
          chk("rst_busy", 32'(busy), 0);
          reset = 1'b0;
          q.delete();
        end else begin
          tick();
        end
        if (l == 1 && px == 0) begin
          l1_busy = busy;
          l1_ovf  = overflow;
        end
      end
    end
    video_de    = 1'b0;
    video_vsync = 1'b0;
    video_hsync = 1'b0;
    wr_ready    = 1'b1;
  endtask

  initial begin
    int derr, jumps, jsz, d, n;
    reset = 1'b1;
    enable = 1'b0;
    wr_ready = 1'b1;
    video_hsync = 1'b0;
    video_vsync = 1'b0;
    video_de = 1'b0;
    video_red = '0;
    video_green = '0;
    video_blue = '0;
    l1_busy = 1'b0;
    l1_ovf = 1'b0;
    repeat (3) tick();
    chk("reset_valid", 32'(wr_valid), 0);
    chk("reset_addr", 32'(wr_addr), 0);
    chk("reset_data", wr_data, 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(frame_done), 0);
    chk("reset_ovf", 32'(overflow), 0);
    reset = 1'b0;
    tick();

    // F1 captured, F2 closes it
    enable = 1'b1;
    tick();
    q.delete();
    frame(-1, 0, 0, -1, 0, -1);
    chk("f1_busy", 32'(l1_busy), 1);
    chk("f1_done_cnt", 32'(done_cnt), 0);
    frame(-1, 0, 0, -1, 0, -1);
    chk("f2_busy", 32'(l1_busy), 0);
    chk("f1_done_pulse", 32'(done_cnt), 1);
    chk("f1_count", 32'(q.size()), NPX);
    n = (q.size() < NPX) ? q.size() : NPX;
    for (int i = 0; i < n; i++) begin
      chk("f1_addr", 32'(q[i][51:32]), 32'(i));
      chk("f1_data", q[i][31:0], exp_px(i));
    end
    if (q.size() > 261) begin
      chk("px261_addr", 32'(q[261][51:32]), 261);
      chk("px261_data", q[261][31:0], 32'hFFB649FF);
    end else begin
      chk("px261_present", 32'(q.size()), 262);
    end

    // F3 captured with a 10-cycle sink stall
    q.delete();
    frame(6, 40, 10, -1, 0, -1);
    chk("f3_ovf", 32'(overflow), 1);
    frame(-1, 0, 0, -1, 0, -1);
    chk("f4_ovf_l1", 32'(l1_ovf), 1);
    chk("f4_ovf_end", 32'(overflow), 1);
    chk("f3_done_pulse", 32'(done_cnt), 2);
    chk("stall_count", 32'(q.size()), NPX - 7);
    derr = 0;
    jumps = 0;
    jsz = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i][31:0] !== exp_px(int'(q[i][51:32]))) derr++;
      if (i > 0) begin
        d = int'(q[i][51:32]) - int'(q[i-1][51:32]);
        if (d != 1) begin
          jumps++;
          jsz = d;
        end
      end
    end
    chk("stall_data", 32'(derr), 0);
    chk("stall_gaps", 32'(jumps), 1);
    chk("stall_gap_size", 32'(jsz), 8);
    if (q.size() > 0) begin
      chk("stall_first", 32'(q[0][51:32]), 0);
      chk("stall_last", 32'(q[q.size()-1][51:32]), NPX - 1);
    end

    // F5 captured, enable dropped mid-frame
    q.delete();
    frame(-1, 0, 0, -1, 0, 6);
    chk("f5_ovf_clr", 32'(l1_ovf), 0);
    chk("f5_busy", 32'(l1_busy), 1);
    chk("f5_busy_end", 32'(busy), 1);
    chk("f5_count", 32'(q.size()), NPX);
    q.delete();
    frame(-1, 0, 0, -1, 0, -1);
    chk("f6_busy", 32'(l1_busy), 0);
    chk("f6_writes", 32'(q.size()), 0);
    chk("f5_done_pulse", 32'(done_cnt), 3);

    // F7 reset mid-line with three queued, F8 after re-arm
    enable = 1'b1;
    tick();
    frame(6, 38, 2, 6, 40, -1);
    chk("f7_writes", 32'(q.size()), 0);
    chk("f7_ovf", 32'(overflow), 0);
    frame(-1, 0, 0, -1, 0, -1);
    chk("f8_busy", 32'(l1_busy), 1);
    frame(-1, 0, 0, -1, 0, -1);
    chk("f8_count", 32'(q.size()), NPX);
    if (q.size() > 0) begin
      chk("f8_first", 32'(q[0][51:32]), 0);
      chk("f8_first_data", q[0][31:0], exp_px(0));
    end
    chk("total_done", 32'(done_cnt), 4);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
